led_stream_decoder: RTL and testbench

LED_STREAM_DECODER -- requirements
Module: led_stream_decoder

---
 rtl/led_stream_decoder.sv | 112 +++++++++++
 tb/tb_led_stream_decoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_stream_decoder.sv
// Double-buffered LED matrix stream decoder: captures a multiplexed pixel stream
// into a write buffer, swaps it to display each frame, and row-scans the display buffer.
module led_stream_decoder #(
   parameter int FRAME_CYCLES = 256128,
   parameter int SCAN_DIV     = 2000
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic [9:0] LEDin,
   output logic [3:0] ROW_SEL,
   output logic [7:0] COL_R,
   output logic [7:0] COL_G,
   output logic       FRAME_DONE,
   output logic [2:0] BALL_X,
   output logic [3:0] BALL_Y,
   output logic       BALL_VALID
);

   localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

   logic [FW-1:0]     frame_cnt;
   logic [SW-1:0]     scan_cnt;
   logic [15:0][7:0]  wr_r, wr_g, dsp_r, dsp_g;
   logic [15:0][7:0]  wr_r_nx, wr_g_nx;
   logic [2:0]        ball_lx, ball_lx_nx;
   logic [3:0]        ball_ly, ball_ly_nx;
   logic              ball_seen, ball_seen_nx;
   logic              terminal;
   logic [3:0]        cap_row;
   logic [2:0]        cap_col;
   logic              led_unused;

   assign cap_row    = LEDin[6:3];
   assign cap_col    = LEDin[2:0];
   assign led_unused = LEDin[7];
   assign terminal   = (frame_cnt == FRAME_LAST);

   // Capture is resolved combinationally so the terminal-cycle pixel lands in the swapped frame.
   always_comb begin
      wr_r_nx      = wr_r;
      wr_g_nx      = wr_g;
      ball_lx_nx   = ball_lx;
      ball_ly_nx   = ball_ly;
      ball_seen_nx = ball_seen;
      if (LEDin[9]) wr_r_nx[cap_row][cap_col] = 1'b1;
      if (LEDin[8]) wr_g_nx[cap_row][cap_col] = 1'b1;
      if (LEDin[9:8] == 2'b01) begin
         ball_lx_nx   = cap_col;
         ball_ly_nx   = cap_row;
         ball_seen_nx = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         frame_cnt  <= '0;
         wr_r       <= '0;
         wr_g       <= '0;
         dsp_r      <= '0;
         dsp_g      <= '0;
         ball_lx    <= '0;
         ball_ly    <= '0;
         ball_seen  <= 1'b0;
         FRAME_DONE <= 1'b0;
         BALL_X     <= '0;
         BALL_Y     <= '0;
         BALL_VALID <= 1'b0;
      end else begin
         frame_cnt  <= terminal ? '0 : frame_cnt + FW'(1);
         FRAME_DONE <= terminal;
         ball_lx    <= ball_lx_nx;
         ball_ly    <= ball_ly_nx;
         if (terminal) begin
            dsp_r      <= wr_r_nx;
            dsp_g      <= wr_g_nx;
            wr_r       <= '0;
            wr_g       <= '0;
            ball_seen  <= 1'b0;
            BALL_VALID <= ball_seen_nx;
            if (ball_seen_nx) begin
               BALL_X <= ball_lx_nx;
               BALL_Y <= ball_ly_nx;
            end
         end else begin
            wr_r      <= wr_r_nx;
            wr_g      <= wr_g_nx;
            ball_seen <= ball_seen_nx;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         scan_cnt <= '0;
         ROW_SEL  <= '0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= '0;
         ROW_SEL  <= ROW_SEL + 4'd1;
      end else begin
         scan_cnt <= scan_cnt + SW'(1);
      end
   end

   always_comb begin
      COL_R = dsp_r[ROW_SEL];
      COL_G = dsp_g[ROW_SEL];
   end

endmodule

// File: tb/tb_led_stream_decoder.sv
// Self-checking bench for led_stream_decoder: directed scenarios plus random stream,
// all checked each cycle against a time-indexed behavioural model.
module tb_led_stream_decoder;

   localparam int FC = 16;
   localparam int SD = 4;

   logic       CLK = 1'b0;
   logic       RSTn;
   logic [9:0] LEDin;
   logic [3:0] ROW_SEL;
   logic [7:0] COL_R, COL_G;
   logic       FRAME_DONE;
   logic [2:0] BALL_X;
   logic [3:0] BALL_Y;
   logic       BALL_VALID;

   led_stream_decoder #(.FRAME_CYCLES(FC), .SCAN_DIV(SD)) dut (
      .CLK(CLK), .RSTn(RSTn), .LEDin(LEDin), .ROW_SEL(ROW_SEL),
      .COL_R(COL_R), .COL_G(COL_G), .FRAME_DONE(FRAME_DONE),
      .BALL_X(BALL_X), .BALL_Y(BALL_Y), .BALL_VALID(BALL_VALID)
   );

   always #5 CLK = ~CLK;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // Model: m_t = clock edges since reset release; everything else is pixel sets.
   bit m_wr_r[16][8], m_wr_g[16][8], m_dsp_r[16][8], m_dsp_g[16][8];
   int m_t;
   bit m_done, m_seen, m_valid;
   int m_lx, m_ly, m_bx, m_by;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] px(input bit red, input bit green, input int row, input int col);
      logic [3:0] r;
      logic [2:0] c;
      r = 4'(row);
      c = 3'(col);
      return {red, green, 1'b0, r, c};
   endfunction

   function automatic logic [7:0] disp_row(input bit green, input int row);
      logic [7:0] v;
      v = '0;
      for (int c = 0; c < 8; c++) v[c] = green ? m_dsp_g[row][c] : m_dsp_r[row][c];
      return v;
   endfunction

   task automatic model_edge(input logic rstn, input logic [9:0] led);
      int r, c;
      if (!rstn) begin
         foreach (m_wr_r[i, j]) begin
            m_wr_r[i][j] = 0; m_wr_g[i][j] = 0; m_dsp_r[i][j] = 0; m_dsp_g[i][j] = 0;
         end
         m_t = 0; m_done = 0; m_seen = 0; m_valid = 0;
         m_lx = 0; m_ly = 0; m_bx = 0; m_by = 0;
      end else begin
         r = int'(led[6:3]);
         c = int'(led[2:0]);
         if (led[9]) m_wr_r[r][c] = 1;
         if (led[8]) m_wr_g[r][c] = 1;
         if (led[9:8] == 2'b01) begin
            m_lx = c; m_ly = r; m_seen = 1;
         end
         m_done = (m_t % FC == FC - 1);
         if (m_done) begin
            m_dsp_r = m_wr_r;
            m_dsp_g = m_wr_g;
            foreach (m_wr_r[i, j]) begin
               m_wr_r[i][j] = 0; m_wr_g[i][j] = 0;
            end
            m_valid = m_seen;
            if (m_seen) begin
               m_bx = m_lx; m_by = m_ly;
            end
            m_seen = 0;
         end
         m_t++;
      end
   endtask

   task automatic check_all();
      int row;
      row = (m_t / SD) % 16;
      chk("row_sel",    32'(ROW_SEL),    32'(row));
      chk("col_r",      32'(COL_R),      32'(disp_row(0, row)));
      chk("col_g",      32'(COL_G),      32'(disp_row(1, row)));
      chk("frame_done", 32'(FRAME_DONE), 32'(m_done));
      chk("ball_x",     32'(BALL_X),     32'(m_bx));
      chk("ball_y",     32'(BALL_Y),     32'(m_by));
      chk("ball_valid", 32'(BALL_VALID), 32'(m_valid));
   endtask

   task automatic cycle(input logic rstn, input logic [9:0] led);
      RSTn  = rstn;
      LEDin = led;
      @(posedge CLK);
      model_edge(rstn, led);
      #1;
      check_all();
   endtask

   task automatic align(input int phase);
      for (int i = 0; i < FC && (m_t % FC) != phase; i++) cycle(1'b1, 10'd0);
   endtask

   initial begin
      int ra, ca, rb, cb, steps, found;
      logic [3:0] prev_row;
      logic [9:0] led;
      bit shown;

      RSTn = 1'b0;
      LEDin = '0;
      for (int i = 0; i < 3; i++) cycle(1'b0, 10'($urandom));
      chk("reset_row",   32'(ROW_SEL), 0);
      chk("reset_col_r", 32'(COL_R), 0);
      chk("reset_valid", 32'(BALL_VALID), 0);

      // Red pixel at row 13, column 3 held continuously.
      for (int i = 0; i < 16; i++) cycle(1'b1, 10'b1001101000 + 10'd3);
      chk("r28_done", 32'(FRAME_DONE), 1);
      found = 0;
      for (int i = 0; i < 100 && found == 0; i++) begin
         if (ROW_SEL == 4'd13) found = 1;
         else cycle(1'b1, 10'b1001101000 + 10'd3);
      end
      chk("r28_row13_seen", 32'(found), 1);
      chk("r28_col_r", 32'(COL_R), 32'h08);
      chk("r28_col_g", 32'(COL_G), 0);
      chk("r28_valid", 32'(BALL_VALID), 0);

      // Four frames with two green-only pixels each, then one idle frame.
      align(0);
      for (int f = 0; f < 5; f++) begin
         for (int k = 0; k < 16; k++) begin
            led = (f < 4 && k == 0) ? px(0, 1, 5, 2) : (f < 4 && k == 1) ? px(0, 1, 9, 6) : 10'd0;
            cycle(1'b1, led);
            shown = (k == 15) ? (f < 4) : (f >= 1);
            if (shown && ((m_t / SD) % 16) == 5) chk("r29_green_row5", 32'(COL_G), 32'h04);
            if (shown && ((m_t / SD) % 16) == 9) chk("r29_green_row9", 32'(COL_G), 32'h40);
            if (f == 3 && k == 15) begin
               chk("r29_ball_x", 32'(BALL_X), 6);
               chk("r29_ball_y", 32'(BALL_Y), 9);
               chk("r29_valid",  32'(BALL_VALID), 1);
            end
            if (f == 4 && k == 15) begin
               chk("r31_valid",  32'(BALL_VALID), 0);
               chk("r31_ball_x", 32'(BALL_X), 6);
               chk("r31_ball_y", 32'(BALL_Y), 9);
               chk("r31_col_r",  32'(COL_R), 0);
               chk("r31_col_g",  32'(COL_G), 0);
            end
         end
      end

      // Pixel A in the terminal cycle, pixel B in the cycle after it.
      align(FC - 1);
      ra = ((m_t + 1) / SD) % 16;
      ca = int'($urandom_range(0, 7));
      cycle(1'b1, px(1, 0, ra, ca));
      chk("r30_a_swapped", 32'(COL_R), 32'(8'(1 << ca)));
      rb = ((m_t + 16) / SD) % 16;
      cb = (ca + 3) % 8;
      cycle(1'b1, px(1, 0, rb, cb));
      chk("r30_b_hidden", 32'(COL_R), 32'(8'(1 << ca)));
      align(0);
      chk("r30_b_next_frame", 32'(COL_R), 32'(8'(1 << cb)));

      // Idle scan: 16 row steps in 64 cycles.
      steps = 0;
      prev_row = ROW_SEL;
      for (int i = 0; i < 64; i++) begin
         cycle(1'b1, 10'd0);
         if (ROW_SEL != prev_row) steps++;
         prev_row = ROW_SEL;
      end
      chk("r32_row_steps", 32'(steps), 16);

      // Reset mid-frame with pixels captured.
      align(0);
      for (int i = 0; i < 10; i++)
         cycle(1'b1, px(1, 1, int'($urandom_range(0, 15)), int'($urandom_range(0, 7))));
      cycle(1'b0, px(1, 1, 3, 3));
      chk("r33_row",   32'(ROW_SEL), 0);
      chk("r33_col_r", 32'(COL_R), 0);
      chk("r33_col_g", 32'(COL_G), 0);
      chk("r33_done",  32'(FRAME_DONE), 0);
      chk("r33_bx",    32'(BALL_X), 0);
      chk("r33_by",    32'(BALL_Y), 0);
      chk("r33_valid", 32'(BALL_VALID), 0);
      for (int i = 0; i < 16; i++) begin
         cycle(1'b1, 10'd0);
         chk("r33_done_timing", 32'(FRAME_DONE), 32'(i == 15));
         chk("r33_disp_r", 32'(COL_R), 0);
         chk("r33_disp_g", 32'(COL_G), 0);
      end

      // Random stream with sparse resets.
      for (int i = 0; i < 400; i++) begin
         led = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom);
         cycle(($urandom_range(0, 63) != 0) ? 1'b1 : 1'b0, led);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
